hci_mem_mux_static_ctrl: RTL
============================

HCI_MEM_MUX_STATIC_CTRL -- requirements
Module: hci_mem_mux_static_ctrl

Interface
REQ-001 SHALL have parameter NB_CHAN, default 2, number of requesters sharing the static mux (>=2).
REQ-002 SHALL have parameter MAX_OUTSTANDING, default 4, maximum in-flight reads (>=1).
REQ-003 SHALL derive SW = $clog2(NB_CHAN) and CW = $clog2(MAX_OUTSTANDING+1) internally.
REQ-004 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_i  input  1  reset, synchronous and active-high.
REQ-006 own_req_i  input  NB_CHAN  per-requester ownership request, level; held for the whole session.
REQ-007 own_gnt_o  output  NB_CHAN  one-hot ownership grant, or all-zero.
REQ-008 sel_o  output  SW  select driven into the static mux.
REQ-009 in_req_i  input  1  memory request from the mux side (current owner).
REQ-010 in_wen_i  input  1  HCI wen of that request; 1 = read.
REQ-011 in_gnt_o  output  1  gated grant returned toward the mux.
REQ-012 out_req_o  output  1  gated request toward memory.
REQ-013 out_gnt_i  input  1  memory grant.
REQ-014 out_r_valid_i  input  1  memory read response valid.
REQ-015 outstanding_o  output  CW  current in-flight read count.
REQ-016 busy_o  output  1  high whenever the state is not IDLE.
REQ-017 err_o  output  1  sticky protocol error flag.

Function
REQ-018 SHALL implement the FSM states IDLE, OWN and DRAIN.
REQ-019 In IDLE, if any own_req_i bit is set, SHALL choose a winner round-robin: search starts at last_owner+1 mod NB_CHAN; SHALL load sel_o with the winner and move to OWN on the next edge.
REQ-020 In IDLE with no request, SHALL stay in IDLE and hold sel_o at last_owner.
REQ-021 SHALL assert own_gnt_o[sel_o] only in OWN; all bits SHALL be 0 in IDLE and DRAIN.
REQ-022 Latency: own_req_i seen in IDLE at cycle t -> own_gnt_o high at t+1.
REQ-023 In OWN, when own_req_i[sel_o]=0, SHALL move to DRAIN, update last_owner=sel_o and hold sel_o.
REQ-024 In OWN, requests from non-owners SHALL have no effect.
REQ-025 In DRAIN, SHALL stay until outstanding_q==0, then move to IDLE; sel_o SHALL be held so responses reach the old owner.
REQ-026 Owner switch minimum: release at t -> DRAIN at t+1 -> IDLE at t+1+drain -> next OWN one cycle later.
REQ-027 Gating: full = (outstanding_q==MAX_OUTSTANDING); out_req_o = in_req_i & OWN & ~(full & in_wen_i).
REQ-028 in_gnt_o = out_gnt_i & out_req_o (purely combinational; requests outside OWN are never granted).
REQ-029 Counter: +1 on out_req_o & out_gnt_i & in_wen_i; -1 on out_r_valid_i; both in the same cycle -> unchanged.
REQ-030 Writes (in_wen_i=0) SHALL NOT be counted and SHALL NOT be blocked by full.
REQ-031 At full, a read issued and a response arriving in the same cycle SHALL still be blocked, because gating uses the registered count.
REQ-032 out_r_valid_i with outstanding_q==0 and no same-cycle increment SHALL set err_o; the count SHALL stay 0 (no underflow).
REQ-033 The counter SHALL never exceed MAX_OUTSTANDING.
REQ-034 outstanding_o SHALL equal the registered count.

Reset
REQ-035 On rst_i=1 at an edge, SHALL set state=IDLE, sel_o=0, last_owner=NB_CHAN-1, counter=0 and err_o=0, overriding every other event in that cycle.
REQ-036 During and after reset, own_gnt_o=0, busy_o=0 and out_req_o=0; the first arbitration after reset SHALL favour channel 0.
REQ-037 Reset mid-DRAIN or mid-OWN SHALL discard outstanding state; responses arriving after reset SHALL set err_o per REQ-032.

Verification
REQ-038 Reset, then own_req_i=2'b11 -> next cycle own_gnt_o=2'b01, sel_o=0, busy_o=1.
REQ-039 Ch0 owner issues 4 granted reads with no responses (MAX=4) -> outstanding_o=4; 5th read out_req_o=0, in_gnt_o=0; a write still passes.
REQ-040 Ch0 releases with outstanding 2 and ch1 requesting -> DRAIN, own_gnt_o=0, sel_o=0; after 2 r_valid -> IDLE, then own_gnt_o=2'b10, sel_o=1.
REQ-041 Granted read and r_valid in the same cycle at count 3 -> count stays 3; r_valid at count 0 -> err_o=1 and stays 1 until reset.
REQ-042 Assert rst_i while in OWN with count 2 -> next cycle state IDLE, count 0, own_gnt_o=0, sel_o=0.
REQ-043 NB_CHAN=3, all requesting continuously with immediate releases -> grant order 0,1,2,0.

Source files
------------

// File: rtl/hci_mem_mux_static_ctrl.sv
// Ownership controller for a statically selected HCI memory mux: round-robin
// session arbitration, read-outstanding gating and drain before owner switch.
module hci_mem_mux_static_ctrl #(
  parameter int unsigned NB_CHAN         = 2,
  parameter int unsigned MAX_OUTSTANDING = 4,
  localparam int unsigned SW = $clog2(NB_CHAN),
  localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NB_CHAN-1:0] own_req_i,
  output logic [NB_CHAN-1:0] own_gnt_o,
  output logic [SW-1:0]      sel_o,
  input  logic               in_req_i,
  input  logic               in_wen_i,
  output logic               in_gnt_o,
  output logic               out_req_o,
  input  logic               out_gnt_i,
  input  logic               out_r_valid_i,
  output logic [CW-1:0]      outstanding_o,
  output logic               busy_o,
  output logic               err_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [SW-1:0] sel_q, sel_d;
  logic [SW-1:0] last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;

  logic [SW-1:0] win;
  logic          found;
  int unsigned   idx;
  logic          full;
  logic          inc;
  logic          dec;

  // State register; reset overrides every other event in the cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      sel_q   <= '0;
      last_q  <= SW'(NB_CHAN - 1);
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Round-robin search starting just after the previous owner.
  always_comb begin
    win   = last_q;
    found = 1'b0;
    idx   = 0;
    for (int unsigned i = 1; i <= NB_CHAN; i++) begin
      idx = (32'(last_q) + i) % NB_CHAN;
      if (!found && own_req_i[SW'(idx)]) begin
        win   = SW'(idx);
        found = 1'b1;
      end
    end
  end

  // Next-state and select logic.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (|own_req_i) begin
          sel_d   = win;
          state_d = OWN;
        end else begin
          sel_d = last_q;
        end
      end
      OWN: begin
        if (!own_req_i[sel_q]) begin
          state_d = DRAIN;
          last_d  = sel_q;
        end
      end
      DRAIN: begin
        if (cnt_q == '0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Gating uses the registered count, so a same-cycle response cannot unblock a read.
  always_comb begin
    full      = (cnt_q == CW'(MAX_OUTSTANDING));
    out_req_o = in_req_i & (state_q == OWN) & ~(full & in_wen_i);
    in_gnt_o  = out_gnt_i & out_req_o;
    inc       = out_req_o & out_gnt_i & in_wen_i;
    dec       = out_r_valid_i;
  end

  // Outstanding-read counter with sticky underflow error.
  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (inc && !dec) begin
      cnt_d = cnt_q + CW'(1);
    end else if (dec && !inc) begin
      if (cnt_q == '0) err_d = 1'b1;
      else             cnt_d = cnt_q - CW'(1);
    end
  end

  always_comb begin
    own_gnt_o = '0;
    if (state_q == OWN) own_gnt_o[sel_q] = 1'b1;
  end

  assign sel_o         = sel_q;
  assign outstanding_o = cnt_q;
  assign busy_o        = (state_q != IDLE);
  assign err_o         = err_q;

endmodule
